// File: rtl/fol_filter_pkg.sv
// Shared widths and helpers for the multichannel first-order low-pass filter.
// State is Q(DW).GB; the difference carries one extra bit and the product is d x a at full width.
package fol_filter_pkg;
   localparam int DW  = 16;
   localparam int CW  = 16;
   localparam int GB  = 8;
   localparam int SW  = DW + GB;
   localparam int DFW = SW + 1;
   localparam int PW  = DW + GB + 1 + CW;

   function automatic logic signed [SW-1:0] align_x(input logic signed [DW-1:0] x);
      return {x, {GB{1'b0}}};
   endfunction
endpackage

// File: rtl/fol_filter_mc_if.sv
// Sample-side handshake bundle of the filter: input transfer, clear and output pulse.
interface fol_filter_mc_if
   import fol_filter_pkg::*;
#(
   parameter int NCH = 4
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic                 i_valid;
   logic                 o_ready;
   logic [CHW-1:0]       i_ch;
   logic signed [DW-1:0] i_x;
   logic [CW-1:0]        i_a;
   logic                 i_bypass;
   logic                 i_clr;
   logic                 o_valid;
   logic [CHW-1:0]       o_ch;
   logic signed [DW-1:0] o_y;

   modport master (
      output i_valid, i_ch, i_x, i_a, i_bypass, i_clr,
      input  o_ready, o_valid, o_ch, o_y
   );

   modport slave (
      input  i_valid, i_ch, i_x, i_a, i_bypass, i_clr,
      output o_ready, o_valid, o_ch, o_y
   );
endinterface

// File: rtl/fol_state_bank.sv
// Per-channel filter state: NCH words with asynchronous read, one write port
// and a global synchronous clear that wins over a write in the same cycle.
module fol_state_bank
   import fol_filter_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CHW = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 we,
   input  logic [CHW-1:0]       wa,
   input  logic signed [SW-1:0] wd,
   input  logic [CHW-1:0]       ra,
   output logic signed [SW-1:0] rd
);
   logic signed [SW-1:0] mem_q [NCH];
   logic signed [SW-1:0] mem_d [NCH];

   // Next contents: clear, then write, otherwise hold.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         if (clr) begin
            mem_d[i] = '0;
         end else if (we && (wa == CHW'(i))) begin
            mem_d[i] = wd;
         end else begin
            mem_d[i] = mem_q[i];
         end
      end
   end

   // State storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd = mem_q[ra];
endmodule

// File: rtl/fol_filter_mc.sv
// Time-multiplexed first-order low-pass IIR: NCH channels share one multiplier
// through R0 (input), R1 (difference), R2 (product) and R3 (writeback/output).
module fol_filter_mc
   import fol_filter_pkg::*;
#(
   parameter int NCH = 4
) (
   input logic            i_clkp,
   input logic            i_rstp,
   fol_filter_mc_if.slave bus
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic signed [SW-1:0] RND_HALF = SW'(1'b1) << (GB - 1);

   logic                  ready_s, xfer_s;
   logic                  v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, ov_q, ov_d;
   logic [CHW-1:0]        ch0_q, ch0_d, ch1_q, ch1_d, ch2_q, ch2_d, och_q, och_d;
   logic signed [DW-1:0]  x0_q, x0_d, x1_q, x1_d, x2_q, x2_d, oy_q, oy_d;
   logic [CW-1:0]         a0_q, a0_d, a1_q, a1_d;
   logic                  byp0_q, byp0_d, byp1_q, byp1_d, byp2_q, byp2_d;
   logic signed [DFW-1:0] d1_q, d1_d;
   logic signed [SW-1:0]  s1_q, s1_d, s2_q, s2_d;
   logic signed [PW-1:0]  p2_q, p2_d;
   logic signed [SW-1:0]  rd_s, ax0_s, snew_s, rnd_s;

   fol_state_bank #(.NCH(NCH), .CHW(CHW)) u_bank (
      .clk (i_clkp),
      .rst (i_rstp),
      .clr (bus.i_clr),
      .we  (v2_q),
      .wa  (ch2_q),
      .wd  (snew_s),
      .ra  (ch0_q),
      .rd  (rd_s)
   );

   // A channel already in R0 or R1 has not yet written back, so it may not re-enter.
   always_comb begin
      ready_s = 1'b1;
      if (bus.i_clr) begin
         ready_s = 1'b0;
      end else if (v0_q && (ch0_q == bus.i_ch)) begin
         ready_s = 1'b0;
      end else if (v1_q && (ch1_q == bus.i_ch)) begin
         ready_s = 1'b0;
      end else begin
         ready_s = 1'b1;
      end
   end

   assign xfer_s      = bus.i_valid && ready_s;
   assign bus.o_ready = ready_s;

   // Datapath: the operands are sign/zero-extended to PW, so the low PW bits equal the signed product.
   always_comb begin
      ax0_s = align_x(x0_q);
      d1_d  = {ax0_s[SW-1], ax0_s} - {rd_s[SW-1], rd_s};
      p2_d  = {{CW{d1_q[DFW-1]}}, d1_q} * {{DFW{1'b0}}, a1_q};
      if (byp2_q) begin
         snew_s = align_x(x2_q);
      end else begin
         snew_s = s2_q + SW'(p2_q >>> CW);
      end
      rnd_s = snew_s + RND_HALF;
   end

   // Pipeline next state; clear drops everything in flight, including this cycle's output.
   always_comb begin
      ch0_d  = ch0_q;
      x0_d   = x0_q;
      a0_d   = a0_q;
      byp0_d = byp0_q;
      if (xfer_s) begin
         ch0_d  = bus.i_ch;
         x0_d   = bus.i_x;
         a0_d   = bus.i_a;
         byp0_d = bus.i_bypass;
      end else begin
         ch0_d  = ch0_q;
         x0_d   = x0_q;
         a0_d   = a0_q;
         byp0_d = byp0_q;
      end
      v0_d   = xfer_s;
      v1_d   = v0_q && !bus.i_clr;
      v2_d   = v1_q && !bus.i_clr;
      ov_d   = v2_q && !bus.i_clr;
      ch1_d  = ch0_q;
      x1_d   = x0_q;
      a1_d   = a0_q;
      byp1_d = byp0_q;
      s1_d   = rd_s;
      ch2_d  = ch1_q;
      x2_d   = x1_q;
      byp2_d = byp1_q;
      s2_d   = s1_q;
      och_d  = och_q;
      oy_d   = oy_q;
      if (v2_q && !bus.i_clr) begin
         och_d = ch2_q;
         oy_d  = DW'(rnd_s >>> GB);
      end else begin
         och_d = och_q;
         oy_d  = oy_q;
      end
   end

   // Pipeline and output registers.
   always_ff @(posedge i_clkp or posedge i_rstp) begin
      if (i_rstp) begin
         v0_q   <= 1'b0;
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         ov_q   <= 1'b0;
         ch0_q  <= '0;
         ch1_q  <= '0;
         ch2_q  <= '0;
         och_q  <= '0;
         x0_q   <= '0;
         x1_q   <= '0;
         x2_q   <= '0;
         oy_q   <= '0;
         a0_q   <= '0;
         a1_q   <= '0;
         byp0_q <= 1'b0;
         byp1_q <= 1'b0;
         byp2_q <= 1'b0;
         d1_q   <= '0;
         s1_q   <= '0;
         s2_q   <= '0;
         p2_q   <= '0;
      end else begin
         v0_q   <= v0_d;
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         ov_q   <= ov_d;
         ch0_q  <= ch0_d;
         ch1_q  <= ch1_d;
         ch2_q  <= ch2_d;
         och_q  <= och_d;
         x0_q   <= x0_d;
         x1_q   <= x1_d;
         x2_q   <= x2_d;
         oy_q   <= oy_d;
         a0_q   <= a0_d;
         a1_q   <= a1_d;
         byp0_q <= byp0_d;
         byp1_q <= byp1_d;
         byp2_q <= byp2_d;
         d1_q   <= d1_d;
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         p2_q   <= p2_d;
      end
   end

   assign bus.o_valid = ov_q;
   assign bus.o_ch    = och_q;
   assign bus.o_y     = oy_q;
endmodule

// File: tb/tb_fol_filter_mc.sv
// Scoreboard bench for fol_filter_mc: stimulus pushes expected outputs, a monitor
// pops and compares value, channel and arrival cycle of every o_valid pulse.
module tb_fol_filter_mc;
   import fol_filter_pkg::*;

   localparam int NO_HAND = 999999;

   typedef struct {
      int     ch;
      int     y;
      longint cyc;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst = 1'b0;
   int     n_tests = 0;
   int     n_fail = 0;
   longint cyc = 0;
   longint mdl_s [4];
   exp_t   sb_q [$];
   exp_t   mon_e;

   always #5 clk = ~clk;

   fol_filter_mc_if #(.NCH(4)) bus ();
   fol_filter_mc #(.NCH(4)) dut (.i_clkp(clk), .i_rstp(rst), .bus(bus));

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every output pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && bus.o_valid) begin
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_out: ch %0d y %0d at cycle %0d, nothing expected",
                     bus.o_ch, bus.o_y, cyc);
         end else begin
            mon_e = sb_q.pop_front();
            if ((int'(bus.o_y) != mon_e.y) || (int'(bus.o_ch) != mon_e.ch) || (cyc != mon_e.cyc)) begin
               n_fail++;
               $display("FAIL out_check: got ch %0d y %0d cycle %0d, expected ch %0d y %0d cycle %0d",
                        bus.o_ch, bus.o_y, cyc, mon_e.ch, mon_e.y, mon_e.cyc);
            end
         end
      end
   end

   // One transfer; keep=0 marks a sample that is expected to be dropped.
   task automatic xfer(input int ch, input int x, input int a, input bit byp,
                       input bit keep, input int hand, output int stalls);
      int     w;
      longint xl, sn, tcyc;
      exp_t   e;
      bus.i_ch     = 2'(ch);
      bus.i_x      = 16'(x);
      bus.i_a      = 16'(a);
      bus.i_bypass = byp;
      bus.i_valid  = 1'b1;
      #1;
      w = 0;
      while (!bus.o_ready && w < 20) begin
         @(posedge clk);
         #1;
         w++;
      end
      stalls = w;
      if (!bus.o_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_timeout: ch %0d never accepted, ready %0d required 1", ch, bus.o_ready);
         bus.i_valid = 1'b0;
         return;
      end
      tcyc = cyc;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      if (keep) begin
         xl = longint'(x) <<< GB;
         if (byp) sn = xl;
         else sn = mdl_s[ch] + (((xl - mdl_s[ch]) * longint'(a)) >>> CW);
         mdl_s[ch] = sn;
         e.ch  = ch;
         e.y   = (hand != NO_HAND) ? hand : int'((sn + (64'sd1 <<< (GB - 1))) >>> GB);
         e.cyc = tcyc + 4;
         sb_q.push_back(e);
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb_q.size() != 0 && w < 30) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: %0d outputs missing, required 0", sb_q.size());
         sb_q.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Clear pulse with a competing valid sample, which must not transfer.
   task automatic do_clear();
      bus.i_clr   = 1'b1;
      bus.i_valid = 1'b1;
      bus.i_ch    = 2'd3;
      #1;
      check("ready_low_on_clr", longint'(bus.o_ready), 64'sd0);
      @(posedge clk);
      #1;
      bus.i_clr   = 1'b0;
      bus.i_valid = 1'b0;
      for (int i = 0; i < 4; i++) mdl_s[i] = 0;
   endtask

   initial begin
      int st;
      int step_y [4] = '{500, 750, 875, 938};
      int rr_y   [8] = '{50, 100, 150, 200, 75, 150, 225, 300};
      int hz_x   [6] = '{3000, -7000, 12345, -32768, 32767, -1};

      for (int i = 0; i < 4; i++) mdl_s[i] = 0;
      bus.i_valid  = 1'b0;
      bus.i_ch     = 2'd0;
      bus.i_x      = 16'sd0;
      bus.i_a      = 16'd0;
      bus.i_bypass = 1'b0;
      bus.i_clr    = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_o_valid", longint'(bus.o_valid), 64'sd0);
      check("rst_o_ch",    longint'(bus.o_ch),    64'sd0);
      check("rst_o_y",     longint'(bus.o_y),     64'sd0);
      check("rst_o_ready", longint'(bus.o_ready), 64'sd1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int k = 0; k < 4; k++) begin
         xfer(0, 1000, 32768, 1'b0, 1'b1, step_y[k], st);
         if (k > 0) check("step_stall", longint'(st), 64'sd2);
      end
      drain();
      do_clear();

      for (int p = 0; p < 2; p++) begin
         for (int c = 0; c < 4; c++) begin
            xfer(c, 100 * (c + 1), 32768, 1'b0, 1'b1, rr_y[p * 4 + c], st);
            check("rr_stall", longint'(st), 64'sd0);
         end
      end
      drain();
      do_clear();

      for (int i = 0; i < 6; i++) begin
         xfer(2, hz_x[i], 20000, 1'b0, 1'b1, NO_HAND, st);
         if (i > 0) check("hz_stall", longint'(st), 64'sd2);
      end
      drain();
      do_clear();

      for (int i = 0; i < 40; i++) xfer(1, -32768, 65535, 1'b0, 1'b1, NO_HAND, st);
      for (int i = 0; i < 40; i++) xfer(1, 32767, 65535, 1'b0, 1'b1, NO_HAND, st);
      drain();

      xfer(3, -1234, 30000, 1'b1, 1'b1, -1234, st);
      xfer(3, 5000, 0, 1'b0, 1'b1, -1234, st);
      drain();

      xfer(0, 1000, 32768, 1'b0, 1'b0, NO_HAND, st);
      xfer(1, 2000, 32768, 1'b0, 1'b0, NO_HAND, st);
      do_clear();
      xfer(0, 1000, 32768, 1'b0, 1'b1, 500, st);
      drain();

      xfer(0, 1000, 32768, 1'b0, 1'b0, NO_HAND, st);
      xfer(1, 2000, 32768, 1'b0, 1'b0, NO_HAND, st);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) mdl_s[i] = 0;
      xfer(0, 1000, 32768, 1'b0, 1'b1, 500, st);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
